fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage that consumes the hazard unit's PC_write, IF_write and addrSel controls.
- Holds the program counter and the next-PC select mux (PC+4, jump target, branch target).
- Drives the instruction-memory request with a simple valid handshake and owns the IF/ID pipeline register.
- Carries saturating performance counters for stalls, redirects and memory wait cycles.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of each saturating performance counter.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Rst  input  1  asynchronous active-low reset.
- PC_write  input  1  from hazard unit; 1 = PC may update this cycle.
- IF_write  input  1  from hazard unit; 1 = IF/ID may load this cycle.
- addrSel  input  2  from hazard unit; next-PC select: 00 PC+4, 01 jump, 10 branch, 11 reserved.
- JumpTarget  input  32  jump target computed in ID.
- BranchTarget  input  32  branch target computed in EX.
- imem_addr  output  32  instruction address; always equals PC.
- imem_valid  input  1  Instr_in is valid for imem_addr this cycle.
- Instr_in  input  32  instruction word from instruction memory.
- PC  output  32  current program counter.
- IF_ID_Instr  output  32  registered instruction for ID.
- IF_ID_PCPlus4  output  32  registered PC+4 of that instruction.
- IF_ID_Valid  output  1  1 = IF/ID holds a real instruction; 0 = NOP.
- sel_err  output  1  sticky flag; set on addrSel==11 with PC_write=1.
- stall_cnt  output  CNT_W  cycles with PC_write=0.
- redirect_cnt  output  CNT_W  accepted jump/branch redirects.
- imem_wait_cnt  output  CNT_W  cycles with PC_write=1, addrSel=00, imem_valid=0.

Behaviour:
- Reset (Rst=0, async, any cycle including mid-stall): PC=RESET_PC, IF_ID_Instr=32'h0, IF_ID_PCPlus4=0, IF_ID_Valid=0, sel_err=0, all counters=0. Reset overrides every other input.
- imem_addr is combinational from PC; there is no request pulse, and memory answers with imem_valid in the same or a later cycle.
- PC update, evaluated on each posedge in priority order:
  - PC_write=0: PC holds, whatever imem_valid or addrSel are.
  - PC_write=1, addrSel=01: PC<=JumpTarget (redirect). Taken regardless of imem_valid; the pending fetch is abandoned.
  - PC_write=1, addrSel=10: PC<=BranchTarget (redirect), same rules as jump.
  - PC_write=1, addrSel=00, imem_valid=1: PC<=PC+4, 32-bit wrap (32'hFFFF_FFFC+4=0).
  - PC_write=1, addrSel=00, imem_valid=0: PC holds (memory wait).
  - PC_write=1, addrSel=11: PC holds and sel_err<=1. sel_err clears only on reset.
- IF/ID update on each posedge:
  - IF_write=0: hold all IF/ID fields. This covers load stall, jump, branch and jr stall cycles from the hazard unit.
  - IF_write=1, imem_valid=1: IF_ID_Instr<=Instr_in, IF_ID_PCPlus4<=PC+4, IF_ID_Valid<=1.
  - IF_write=1, imem_valid=0: IF_ID_Instr<=0 (NOP), IF_ID_PCPlus4<=0, IF_ID_Valid<=0.
- Latency: an instruction accepted at edge N appears on the IF/ID outputs after edge N; one cycle, no internal buffering.
- IF_write=1 with PC_write=0: IF/ID loads the current fetch while PC holds, so the same instruction can be duplicated. This is legal and is the hazard unit's responsibility.
- Counters: increment on posedge, saturate at all-ones and never wrap.
  - stall_cnt: +1 when PC_write=0.
  - redirect_cnt: +1 when PC_write=1 and addrSel is 01 or 10.
  - imem_wait_cnt: +1 when PC_write=1, addrSel=00 and imem_valid=0.
  - Several counters may increment in the same cycle.
- No internal FSM beyond the PC, IF/ID and counter registers; every control decision is made from the current-cycle inputs.

Test Plan:
- Reset then free-run, with PC_write=IF_write=1, addrSel=00, imem_valid=1 and Instr_in=PC^32'hA5A5_0000:
  - PC sequence 0,4,8,C.
  - IF_ID_Instr lags by one cycle, with IF_ID_PCPlus4=PC_prev+4 and IF_ID_Valid=1.
- Load stall (one cycle of PC_write=0, IF_write=0) at PC=8 -> PC stays 8, IF/ID unchanged, stall_cnt=1; then PC=C.
- Branch redirect, BranchTarget=0x40, two cycles:
  - Cycle 1: PC_write=1, IF_write=0, addrSel=10 -> PC=0x40, IF/ID held.
  - Cycle 2: PC_write=0, IF_write=0 -> PC stays 0x40, IF/ID held, stall_cnt increments.
  - Result: redirect_cnt=1, stall_cnt=1.
- Jump with imem_valid=0 at the same time, JumpTarget=0x100 -> PC=0x100; redirect_cnt=1; imem_wait_cnt unchanged.
- Memory wait, imem_valid=0 for 3 cycles at PC=0x10 -> PC holds 0x10, IF_ID_Valid=0 with Instr=0, imem_wait_cnt=3; then PC=0x14.
- Corner cases:
  - addrSel=11 with PC_write=1 -> PC holds and sel_err=1.
  - Force stall_cnt to all-ones, then stall again -> stays all-ones.
  - Rst low mid-stall -> all outputs return to their reset values immediately, without waiting for Clk.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC, next-PC mux, IF/ID register, perf counters
//
// Purpose:
//   Holds the program counter and selects the next PC (PC+4, jump, branch)
//   under hazard-unit control, presents the PC to instruction memory, owns
//   the IF/ID pipeline register and keeps saturating stall/redirect/wait
//   counters.
//
// Ports:
//   Clk, Rst                    clock; asynchronous active-low reset
//   PC_write, IF_write, addrSel hazard-unit controls
//   JumpTarget, BranchTarget    redirect targets from ID / EX
//   imem_addr                   instruction address (always PC)
//   imem_valid, Instr_in        instruction memory response
//   PC                          current program counter
//   IF_ID_Instr/PCPlus4/Valid   IF/ID pipeline register outputs
//   sel_err                     sticky flag for reserved addrSel with PC_write
//   stall_cnt, redirect_cnt,
//   imem_wait_cnt               saturating performance counters

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             PC_write,
  input  logic             IF_write,
  input  logic [1:0]       addrSel,
  input  logic [31:0]      JumpTarget,
  input  logic [31:0]      BranchTarget,
  output logic [31:0]      imem_addr,
  input  logic             imem_valid,
  input  logic [31:0]      Instr_in,
  output logic [31:0]      PC,
  output logic [31:0]      IF_ID_Instr,
  output logic [31:0]      IF_ID_PCPlus4,
  output logic             IF_ID_Valid,
  output logic             sel_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] imem_wait_cnt
);

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_JUMP   = 2'b01;
  localparam logic [1:0] SEL_BRANCH = 2'b10;
  localparam logic [1:0] SEL_RSVD   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0] pc_plus4;
  logic        redirect;
  logic        mem_wait;

  assign imem_addr = PC;
  assign pc_plus4  = PC + 32'd4;
  assign redirect  = PC_write && (addrSel == SEL_JUMP || addrSel == SEL_BRANCH);
  assign mem_wait  = PC_write && (addrSel == SEL_SEQ) && !imem_valid;

  // Program counter and sticky select error.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      PC      <= RESET_PC;
      sel_err <= 1'b0;
    end else if (PC_write) begin
      case (addrSel)
        SEL_JUMP:   PC <= JumpTarget;
        SEL_BRANCH: PC <= BranchTarget;
        SEL_SEQ:    if (imem_valid) PC <= pc_plus4;
        SEL_RSVD:   sel_err <= 1'b1;
        default:    ;
      endcase
    end
  end

  // IF/ID register: a missing fetch is loaded as a NOP bubble.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      IF_ID_Instr   <= 32'h0;
      IF_ID_PCPlus4 <= 32'h0;
      IF_ID_Valid   <= 1'b0;
    end else if (IF_write) begin
      if (imem_valid) begin
        IF_ID_Instr   <= Instr_in;
        IF_ID_PCPlus4 <= pc_plus4;
        IF_ID_Valid   <= 1'b1;
      end else begin
        IF_ID_Instr   <= 32'h0;
        IF_ID_PCPlus4 <= 32'h0;
        IF_ID_Valid   <= 1'b0;
      end
    end
  end

  // Saturating counters; each stops at all-ones.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_cnt     <= '0;
      redirect_cnt  <= '0;
      imem_wait_cnt <= '0;
    end else begin
      if (!PC_write && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
      if (redirect && redirect_cnt != CNT_MAX)
        redirect_cnt <= redirect_cnt + CNT_ONE;
      if (mem_wait && imem_wait_cnt != CNT_MAX)
        imem_wait_cnt <= imem_wait_cnt + CNT_ONE;
    end
  end

endmodule
